frame_capture_ctrl: RTL and testbench

Controller between the BEP serial decoder and the host readout port. It arms the decoder on each transmission start and supervises reception with an optional timeout. It commits only validated frames into a double-buffered holding bank, and it lets the microcontroller freeze that bank with a lock so that multi-byte reads stay coherent. It replaces the free-running, edge-clocked capture and the bare address mux at the top level.

---
 rtl/bep_pkg.sv | 35 +++
 rtl/frame_capture_ctrl_if.sv | 30 +++
 rtl/frame_bank.sv | 97 +++++++++
 rtl/frame_capture_ctrl.sv | 111 +++++++++++
 tb/tb_frame_capture_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bep_pkg.sv
// Shared BEP definitions: capture FSM encoding, readout address map, status bits and frame constants.
// Pure declarations; no logic, no latency, no flow control.
package bep_pkg;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    RECEIVING = 2'd1,
    CHECK     = 2'd2
  } cap_state_t;

  typedef logic [2:0] rd_addr_t;

  localparam rd_addr_t ADDR_ROOM_LO   = 3'd0;
  localparam rd_addr_t ADDR_ROOM_HI   = 3'd1;
  localparam rd_addr_t ADDR_SET_LO    = 3'd2;
  localparam rd_addr_t ADDR_SET_HI    = 3'd3;
  localparam rd_addr_t ADDR_STATUS    = 3'd4;
  localparam rd_addr_t ADDR_FRAME_CNT = 3'd5;
  localparam rd_addr_t ADDR_ERR_CNT   = 3'd6;

  localparam int STAT_LOCK     = 0;
  localparam int STAT_DATA_NEW = 1;
  localparam int STAT_PENDING  = 2;
  localparam int STAT_OVERRUN  = 3;

  // Fixed fields the decoder's frame_valid check compares against.
  localparam logic [7:0] KNOWN_PREAMBLE = 8'hA5;
  localparam logic [7:0] KNOWN_CONSTANT = 8'h3C;

  typedef struct packed {
    logic [15:0] room;
    logic [15:0] set;
  } temp_frame_t;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Decoder and host readout signals of frame_capture_ctrl; master drives the inputs, slave is the controller.
// Wires only; timing is defined by the controller (rd_data one cycle after rd_addr, no backpressure).
interface frame_capture_ctrl_if;
  import bep_pkg::*;

  logic        transmission_begin;
  logic        frame_full;
  logic        frame_valid;
  logic [15:0] room_temp;
  logic [15:0] set_temp;
  logic        host_lock;
  logic        host_ack;
  rd_addr_t    rd_addr;
  logic        dec_clear;
  logic [7:0]  rd_data;
  logic        data_new;

  modport master (
    output transmission_begin, frame_full, frame_valid, room_temp, set_temp,
    output host_lock, host_ack, rd_addr,
    input  dec_clear, rd_data, data_new
  );

  modport slave (
    input  transmission_begin, frame_full, frame_valid, room_temp, set_temp,
    input  host_lock, host_ack, rd_addr,
    output dec_clear, rd_data, data_new
  );

endinterface

// File: rtl/frame_bank.sv
// Holding/shadow banks with pending/overrun tracking and the registered readout mux.
// Commit lands on the commit edge, rd_data is one cycle behind rd_addr; host_lock freezes the holding bank.
module frame_bank import bep_pkg::*; #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit,
  input  temp_frame_t       frame,
  input  logic              host_lock,
  input  logic              host_ack,
  input  rd_addr_t          rd_addr,
  input  logic [CNT_W-1:0]  frame_cnt,
  input  logic [CNT_W-1:0]  err_cnt,
  output logic [7:0]        rd_data,
  output logic              data_new
);

  temp_frame_t hold_q;
  temp_frame_t shadow_q;
  logic        pending_q;
  logic        overrun_q;
  logic        commit_direct;
  logic        commit_shadow;
  logic        transfer;
  logic [7:0]  status;
  logic [7:0]  rd_mux;

  assign commit_direct = commit & ~host_lock;
  assign commit_shadow = commit & host_lock;
  // A direct commit supersedes a waiting shadow, so the transfer is suppressed.
  assign transfer      = ~host_lock & pending_q & ~commit;

  always_comb begin
    status                = 8'h00;
    status[STAT_LOCK]     = host_lock;
    status[STAT_DATA_NEW] = data_new;
    status[STAT_PENDING]  = pending_q;
    status[STAT_OVERRUN]  = overrun_q;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (rd_addr)
      ADDR_ROOM_LO:   rd_mux = hold_q.room[7:0];
      ADDR_ROOM_HI:   rd_mux = hold_q.room[15:8];
      ADDR_SET_LO:    rd_mux = hold_q.set[7:0];
      ADDR_SET_HI:    rd_mux = hold_q.set[15:8];
      ADDR_STATUS:    rd_mux = status;
      ADDR_FRAME_CNT: rd_mux = 8'(frame_cnt);
      ADDR_ERR_CNT:   rd_mux = 8'(err_cnt);
      default:        rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      data_new  <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      if (commit_direct) begin
        hold_q <= frame;
      end else if (transfer) begin
        hold_q <= shadow_q;
      end

      if (commit_shadow) begin
        shadow_q <= frame;
      end

      if (commit_shadow) begin
        pending_q <= 1'b1;
      end else if (!host_lock) begin
        pending_q <= 1'b0;
      end

      if (commit_shadow && pending_q) begin
        overrun_q <= 1'b1;
      end else if (host_ack && !host_lock) begin
        overrun_q <= 1'b0;
      end

      if (commit_direct || transfer) begin
        data_new <= 1'b1;
      end else if (host_ack) begin
        data_new <= 1'b0;
      end

      rd_data <= rd_mux;
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Arms the BEP decoder, supervises reception, commits validated frames into frame_bank for host readout.
// Commit lands at the end of CHECK; optional RECEIVING timeout compiled in with FRAME_CTRL_TIMEOUT_EN.
module frame_capture_ctrl import bep_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_capture_ctrl_if.slave  bus
);

  cap_state_t        state_q;
  cap_state_t        state_d;
  logic              dec_clear_d;
  logic              commit;
  logic              err_inc;
  logic              tmo_hit;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic [CNT_W-1:0]  err_cnt_q;
  temp_frame_t       frame_in;

  assign frame_in = {bus.room_temp, bus.set_temp};

`ifdef FRAME_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Every (re)start of reception coincides with a decoder clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (dec_clear_d) begin
      tmo_cnt_q <= '0;
    end else if (state_q == RECEIVING) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dec_clear_d = 1'b0;
    commit      = 1'b0;
    err_inc     = 1'b0;
    case (state_q)
      ARMED: begin
        if (bus.transmission_begin) begin
          dec_clear_d = 1'b1;
          state_d     = RECEIVING;
        end
      end
      RECEIVING: begin
        if (bus.frame_full) begin
          state_d = CHECK;
        end else if (bus.transmission_begin) begin
          dec_clear_d = 1'b1;
        end else if (tmo_hit) begin
          err_inc = 1'b1;
          state_d = ARMED;
        end
      end
      CHECK: begin
        state_d = ARMED;
        if (bus.frame_valid) begin
          commit = 1'b1;
        end else begin
          err_inc = 1'b1;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARMED;
      bus.dec_clear <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      bus.dec_clear <= dec_clear_d;
      if (commit) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  frame_bank #(.CNT_W(CNT_W)) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit),
    .frame     (frame_in),
    .host_lock (bus.host_lock),
    .host_ack  (bus.host_ack),
    .rd_addr   (bus.rd_addr),
    .frame_cnt (frame_cnt_q),
    .err_cnt   (err_cnt_q),
    .rd_data   (bus.rd_data),
    .data_new  (bus.data_new)
  );

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: a transaction-level model checked every cycle plus literal spot checks.
module tb_frame_capture_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_capture_ctrl_if bus();

  frame_capture_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model of what the host should see
  logic [15:0] m_room, m_set, s_room, s_set;
  logic [7:0]  m_fcnt, m_err;
  bit          m_pend, m_ovr, m_dn, m_dec;

  // Marks the CHECK cycle of a frame the bench is sending
  bit          c_commit, c_valid;
  logic [15:0] c_room, c_set;

  logic [7:0]  exp_q = 8'h00;
  logic [7:0]  v;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void model_reset();
    m_room = 16'h0; m_set = 16'h0; s_room = 16'h0; s_set = 16'h0;
    m_fcnt = 8'h0;  m_err = 8'h0;
    m_pend = 1'b0;  m_ovr = 1'b0; m_dn = 1'b0; m_dec = 1'b0;
  endfunction

  function automatic logic [7:0] model_byte(input logic [2:0] a);
    case (a)
      3'd0:    return m_room[7:0];
      3'd1:    return m_room[15:8];
      3'd2:    return m_set[7:0];
      3'd3:    return m_set[15:8];
      3'd4:    return {4'b0, m_ovr, m_pend, m_dn, bus.host_lock};
      3'd5:    return m_fcnt;
      3'd6:    return m_err;
      default: return 8'h00;
    endcase
  endfunction

  // Advance one clock and apply the host-visible consequences of the cycle just finished.
  task automatic step();
    bit lk, ak, cm, vl, dn_set;
    logic [15:0] cr, cs;
    lk = bus.host_lock; ak = bus.host_ack;
    cm = c_commit; vl = c_valid; cr = c_room; cs = c_set;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dn_set = 1'b0;
    if (cm && vl) begin
      m_fcnt++;
      if (!lk) begin
        m_room = cr; m_set = cs; m_pend = 1'b0; dn_set = 1'b1;
      end else begin
        if (m_pend) m_ovr = 1'b1;
        s_room = cr; s_set = cs; m_pend = 1'b1;
      end
    end else if (cm) begin
      if (m_err != 8'hFF) m_err++;
    end
    if (!lk && m_pend) begin
      m_room = s_room; m_set = s_set; m_pend = 1'b0; dn_set = 1'b1;
    end
    if (dn_set) m_dn = 1'b1;
    else if (ak) m_dn = 1'b0;
    if (ak && !lk) m_ovr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] val);
    bus.rd_addr = a;
    step();
    val = bus.rd_data;
  endtask

  task automatic send_frame(input bit valid, input logic [15:0] room, input logic [15:0] set);
    bus.transmission_begin = 1'b1;
    step();
    bus.transmission_begin = 1'b0;
    m_dec = 1'b1;
    bus.frame_full = 1'b1; bus.frame_valid = valid;
    bus.room_temp = room;  bus.set_temp = set;
    step();
    m_dec = 1'b0;
    c_commit = 1'b1; c_valid = valid; c_room = room; c_set = set;
    step();
    c_commit = 1'b0;
    bus.frame_full = 1'b0; bus.frame_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [7:0] e;
    e = rst_n ? exp_q : 8'h00;
    chk("rd_data", {8'h00, bus.rd_data}, {8'h00, e});
    chk("data_new", {15'h0, bus.data_new}, {15'h0, m_dn});
    chk("dec_clear", {15'h0, bus.dec_clear}, {15'h0, m_dec});
    exp_q = rst_n ? model_byte(bus.rd_addr) : 8'h00;
  end

  initial begin
    bus.transmission_begin = 1'b0; bus.frame_full = 1'b0; bus.frame_valid = 1'b0;
    bus.room_temp = 16'h0; bus.set_temp = 16'h0;
    bus.host_lock = 1'b0; bus.host_ack = 1'b0; bus.rd_addr = 3'd0;
    c_commit = 1'b0; c_valid = 1'b0; c_room = 16'h0; c_set = 16'h0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    rd(3'd4, v); chk("reset_status", {8'h0, v}, 16'h0000);
    rd(3'd5, v); chk("reset_frame_cnt", {8'h0, v}, 16'h0000);

    // Valid frame, unlocked
    send_frame(1'b1, 16'h00D2, 16'h00C8);
    chk("valid_data_new", {15'h0, bus.data_new}, 16'h0001);
    rd(3'd0, v); chk("valid_room_lo", {8'h0, v}, 16'h00D2);
    rd(3'd2, v); chk("valid_set_lo", {8'h0, v}, 16'h00C8);
    rd(3'd5, v); chk("valid_frame_cnt", {8'h0, v}, 16'h0001);

    // Invalid frame
    do_reset();
    send_frame(1'b0, 16'h1234, 16'h5678);
    rd(3'd6, v); chk("invalid_err_cnt", {8'h0, v}, 16'h0001);
    rd(3'd5, v); chk("invalid_frame_cnt", {8'h0, v}, 16'h0000);
    rd(3'd0, v); chk("invalid_room_lo", {8'h0, v}, 16'h0000);
    chk("invalid_data_new", {15'h0, bus.data_new}, 16'h0000);

    // Lock with overrun, then release
    do_reset();
    bus.host_lock = 1'b1;
    step();
    send_frame(1'b1, 16'h0100, 16'h0011);
    send_frame(1'b1, 16'h0200, 16'h0022);
    rd(3'd4, v); chk("locked_status", {8'h0, v}, 16'h000D);
    rd(3'd1, v); chk("locked_room_hi", {8'h0, v}, 16'h0000);
    bus.host_lock = 1'b0;
    step();
    step();
    chk("release_room_hi", {8'h0, bus.rd_data}, 16'h0002);
    rd(3'd4, v); chk("release_status", {8'h0, v}, 16'h000A);
    bus.host_ack = 1'b1;
    step();
    bus.host_ack = 1'b0;
    rd(3'd4, v); chk("ack_status", {8'h0, v}, 16'h0000);

    // Reception timeout
    do_reset();
    bus.rd_addr = 3'd6;
    bus.transmission_begin = 1'b1;
    step();
    bus.transmission_begin = 1'b0;
    m_dec = 1'b1;
    step();
    m_dec = 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
    repeat (15) step();
    if (m_err != 8'hFF) m_err++;
    rd(3'd6, v); chk("timeout_err_cnt", {8'h0, v}, 16'h0001);
    bus.frame_full = 1'b1; bus.frame_valid = 1'b1; bus.room_temp = 16'hBEEF;
    repeat (4) step();
    bus.frame_full = 1'b0; bus.frame_valid = 1'b0;
    rd(3'd5, v); chk("timeout_no_commit", {8'h0, v}, 16'h0000);
    chk("timeout_data_new", {15'h0, bus.data_new}, 16'h0000);
`else
    repeat (1000) step();
    rd(3'd6, v); chk("no_timeout_err_cnt", {8'h0, v}, 16'h0000);
    bus.frame_full = 1'b1; bus.frame_valid = 1'b1;
    bus.room_temp = 16'hBEEF; bus.set_temp = 16'h0042;
    step();
    c_commit = 1'b1; c_valid = 1'b1; c_room = 16'hBEEF; c_set = 16'h0042;
    step();
    c_commit = 1'b0;
    bus.frame_full = 1'b0; bus.frame_valid = 1'b0;
    chk("late_frame_data_new", {15'h0, bus.data_new}, 16'h0001);
    rd(3'd1, v); chk("late_frame_room_hi", {8'h0, v}, 16'h00BE);
`endif

    // Error counter saturation, frame counter wrap
    do_reset();
    bus.rd_addr = 3'd6;
    repeat (300) send_frame(1'b0, 16'h1111, 16'h2222);
    rd(3'd6, v); chk("err_cnt_saturated", {8'h0, v}, 16'h00FF);
    bus.rd_addr = 3'd5;
    for (int i = 0; i < 257; i++) send_frame(1'b1, 16'(i), 16'h0A0B);
    rd(3'd5, v); chk("frame_cnt_wrapped", {8'h0, v}, 16'h0001);
    rd(3'd0, v); chk("last_room_lo", {8'h0, v}, 16'h0000);

    // Reset in the middle of a frame
    bus.rd_addr = 3'd0;
    bus.transmission_begin = 1'b1;
    step();
    bus.transmission_begin = 1'b0;
    m_dec = 1'b1;
    step();
    m_dec = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_rd_data", {8'h0, bus.rd_data}, 16'h0000);
    chk("midreset_data_new", {15'h0, bus.data_new}, 16'h0000);
    step(); step();
    rst_n = 1'b1;
    bus.frame_full = 1'b1; bus.frame_valid = 1'b1; bus.room_temp = 16'h7777;
    repeat (4) step();
    bus.frame_full = 1'b0; bus.frame_valid = 1'b0;
    chk("postreset_data_new", {15'h0, bus.data_new}, 16'h0000);
    rd(3'd5, v); chk("postreset_frame_cnt", {8'h0, v}, 16'h0000);
    rd(3'd0, v); chk("postreset_room_lo", {8'h0, v}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
